// File: rtl/ifft_8.sv
// ifft_8: frame-based 8-point inverse DFT, complex in / complex out.
//   Collects 8 bins in natural order into a bit-reversed buffer, runs
//   3 radix-2 DIT stages (one butterfly per cycle, 12 cycles), then emits
//   8 time samples in natural order, each scaled by 1/8 (floor) and
//   saturated to DBW bits.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   clear      synchronous frame abort (same effect as rst)
//   din        {imag, real} frequency bin, DBW bits each, signed
//   din_valid  / din_ready   input handshake (ready only while loading)
//   dout       {imag, real} time sample, DBW bits each, signed (registered)
//   dout_valid / dout_ready  output handshake
module ifft_8 #(
  parameter int DBW = 4,
  parameter int IW  = DBW + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [2*DBW-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [2*DBW-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam int PW = IW + 6;
  localparam logic signed [IW-1:0] OUT_MAX = IW'((2 ** (DBW - 1)) - 1);
  localparam logic signed [IW-1:0] OUT_MIN = IW'(-(2 ** (DBW - 1)));

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CALC,
    ST_UNLOAD
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [3:0]           step_q, step_d;
  logic [2*DBW-1:0]     dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;

  logic signed [IW-1:0] mem_re_q [8];
  logic signed [IW-1:0] mem_im_q [8];

  // Butterfly addressing and twiddle selection
  logic [1:0]           stage;
  logic [1:0]           bfly;
  logic [2:0]           idx_a, idx_b;
  logic [1:0]           tw_idx;
  logic signed [3:0]    tw_re, tw_im;

  // Butterfly datapath
  logic signed [IW-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] wr_x, wi_x, br_x, bi_x;
  logic signed [PW-1:0] sum_re, sum_im, shr_re, shr_im;
  logic signed [IW-1:0] p_re, p_im;
  logic signed [IW-1:0] new_a_re, new_a_im, new_b_re, new_b_im;

  // Load / unload data
  logic signed [IW-1:0] ld_re, ld_im;
  logic [2:0]           rd_idx;
  logic [2*DBW-1:0]     rd_word;

  // Memory write controls
  logic                 wr_a, wr_b;
  logic [2:0]           wa_addr;
  logic signed [IW-1:0] wa_re, wa_im;

  function automatic logic [DBW-1:0] sat_scale(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
    logic [DBW-1:0]       r;
    s = v >>> 3;
    if (s > OUT_MAX) begin
      r = OUT_MAX[DBW-1:0];
    end else if (s < OUT_MIN) begin
      r = OUT_MIN[DBW-1:0];
    end else begin
      r = s[DBW-1:0];
    end
    return r;
  endfunction

  // Stage s uses span 2^s; the lower index of each pair is the butterfly
  // number with a zero inserted at bit s, so pairs come out ascending.
  always_comb begin
    stage = step_q[3:2];
    bfly  = step_q[1:0];
    case (stage)
      2'd0: begin
        idx_a  = {bfly, 1'b0};
        tw_idx = 2'd0;
      end
      2'd1: begin
        idx_a  = {bfly[1], 1'b0, bfly[0]};
        tw_idx = {bfly[0], 1'b0};
      end
      default: begin
        idx_a  = {1'b0, bfly};
        tw_idx = bfly;
      end
    endcase
    idx_b = idx_a | (3'b001 << stage);
  end

  // e^(+j*pi*t/4) with 2 fractional bits
  always_comb begin
    case (tw_idx)
      2'd0:    begin tw_re = 4'sd4;  tw_im = 4'sd0; end
      2'd1:    begin tw_re = 4'sd3;  tw_im = 4'sd3; end
      2'd2:    begin tw_re = 4'sd0;  tw_im = 4'sd4; end
      default: begin tw_re = -4'sd3; tw_im = 4'sd3; end
    endcase
  end

  always_comb begin
    a_re = mem_re_q[idx_a];
    a_im = mem_im_q[idx_a];
    b_re = mem_re_q[idx_b];
    b_im = mem_im_q[idx_b];
    wr_x = {{(PW-4){tw_re[3]}}, tw_re};
    wi_x = {{(PW-4){tw_im[3]}}, tw_im};
    br_x = {{(PW-IW){b_re[IW-1]}}, b_re};
    bi_x = {{(PW-IW){b_im[IW-1]}}, b_im};
    // Full-width sum first, then a single floor shift
    sum_re = (wr_x * br_x) - (wi_x * bi_x);
    sum_im = (wr_x * bi_x) + (wi_x * br_x);
    shr_re = sum_re >>> 2;
    shr_im = sum_im >>> 2;
    p_re   = shr_re[IW-1:0];
    p_im   = shr_im[IW-1:0];
    new_a_re = a_re + p_re;
    new_a_im = a_im + p_im;
    new_b_re = a_re - p_re;
    new_b_im = a_im - p_im;
  end

  always_comb begin
    ld_re   = {{(IW-DBW){din[DBW-1]}}, din[DBW-1:0]};
    ld_im   = {{(IW-DBW){din[2*DBW-1]}}, din[2*DBW-1:DBW]};
    // While a sample is shown, prefetch the next one for the transfer edge
    rd_idx  = dout_valid_q ? (cnt_q + 3'd1) : cnt_q;
    rd_word = {sat_scale(mem_im_q[rd_idx]), sat_scale(mem_re_q[rd_idx])};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    wr_a         = 1'b0;
    wr_b         = 1'b0;
    wa_addr      = idx_a;
    wa_re        = new_a_re;
    wa_im        = new_a_im;
    case (state_q)
      ST_LOAD: begin
        if (din_valid) begin
          wr_a    = 1'b1;
          wa_addr = {cnt_q[0], cnt_q[1], cnt_q[2]};
          wa_re   = ld_re;
          wa_im   = ld_im;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_CALC;
            step_d  = '0;
          end
        end
      end
      ST_CALC: begin
        wr_a   = 1'b1;
        wr_b   = 1'b1;
        step_d = step_q + 4'd1;
        if (step_q == 4'd11) begin
          state_d = ST_UNLOAD;
          step_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_UNLOAD: begin
        if (!dout_valid_q) begin
          dout_d       = rd_word;
          dout_valid_d = 1'b1;
        end else if (dout_ready) begin
          if (cnt_q == 3'd7) begin
            dout_valid_d = 1'b0;
            state_d      = ST_LOAD;
            cnt_d        = '0;
          end else begin
            cnt_d  = cnt_q + 3'd1;
            dout_d = rd_word;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      step_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here
  always_ff @(posedge clk) begin
    if (wr_a) begin
      mem_re_q[wa_addr] <= wa_re;
      mem_im_q[wa_addr] <= wa_im;
    end
    if (wr_b) begin
      mem_re_q[idx_b] <= new_b_re;
      mem_im_q[idx_b] <= new_b_im;
    end
  end

  assign din_ready  = (state_q == ST_LOAD);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ifft_8.sv
// tb_ifft_8: self-checking bench for ifft_8 (directed frames plus a
// random back-to-back run), scored against an arithmetic reference model.
module tb_ifft_8;

  localparam int DBW = 4;

  typedef int frame_t [8];

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [2*DBW-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [2*DBW-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  ifft_8 #(.DBW(DBW), .IW(DBW + 4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int got, input int expv);
    n_total++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
  endtask

  function automatic int bitrev3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  function automatic int clamp_out(input int v);
    if (v > 7) return 7;
    if (v < -8) return -8;
    return v;
  endfunction

  // Reference: bit-reversed load, three radix-2 DIT stages with the 4-entry
  // quarter-precision twiddle set, then floor(/8) and saturation.
  function automatic void ifft_model(input frame_t xr, input frame_t xi,
                                     output frame_t yr, output frame_t yi);
    frame_t ar, ai;
    int tw_r [4];
    int tw_i [4];
    tw_r = '{4, 3, 0, -3};
    tw_i = '{0, 3, 4, 3};
    for (int k = 0; k < 8; k++) begin
      ar[bitrev3(k)] = xr[k];
      ai[bitrev3(k)] = xi[k];
    end
    for (int s = 0; s < 3; s++) begin
      int span;
      span = 1 << s;
      for (int i = 0; i < 8; i++) begin
        if ((i & span) == 0) begin
          int t, wr, wi, br, bi, pr, pim, a0r, a0i;
          t   = (i % span) * (4 / span);
          wr  = tw_r[t];
          wi  = tw_i[t];
          br  = ar[i + span];
          bi  = ai[i + span];
          pr  = (wr * br - wi * bi) >>> 2;
          pim = (wr * bi + wi * br) >>> 2;
          a0r = ar[i];
          a0i = ai[i];
          ar[i] = a0r + pr;
          ai[i] = a0i + pim;
          ar[i + span] = a0r - pr;
          ai[i + span] = a0i - pim;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      yr[n] = clamp_out(ar[n] >>> 3);
      yi[n] = clamp_out(ai[n] >>> 3);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int exp_re [$];
  int exp_im [$];
  int log_re [$];
  int log_im [$];
  frame_t part_re, part_im, mon_yr, mon_yi;
  int part_n = 0;
  bit filled_prev = 0;
  bit stall_prev  = 0;
  logic [2*DBW-1:0] held_dout;
  logic signed [DBW-1:0] m_re, m_im;
  int e_re, e_im;

  always @(negedge clk) begin
    if (rst || clear) begin
      part_n      = 0;
      exp_re.delete();
      exp_im.delete();
      filled_prev = 0;
      stall_prev  = 0;
    end else begin
      if (filled_prev) chk("din_ready_drop_after_8th", int'(din_ready), 0);
      filled_prev = 0;
      if (stall_prev) begin
        chk("stall_valid_hold", int'(dout_valid), 1);
        chk("stall_dout_hold", int'(dout), int'(held_dout));
      end
      stall_prev = dout_valid && !dout_ready;
      held_dout  = dout;
      if (dout_valid) chk("din_ready_low_in_unload", int'(din_ready), 0);
      if (din_valid && din_ready) begin
        m_re = din[DBW-1:0];
        m_im = din[2*DBW-1:DBW];
        part_re[part_n] = m_re;
        part_im[part_n] = m_im;
        part_n++;
        if (part_n == 8) begin
          ifft_model(part_re, part_im, mon_yr, mon_yi);
          for (int n = 0; n < 8; n++) begin
            exp_re.push_back(mon_yr[n]);
            exp_im.push_back(mon_yi[n]);
          end
          part_n      = 0;
          filled_prev = 1;
        end
      end
      if (dout_valid && dout_ready) begin
        m_re = dout[DBW-1:0];
        m_im = dout[2*DBW-1:DBW];
        log_re.push_back(int'(m_re));
        log_im.push_back(int'(m_im));
        if (exp_re.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e_re = exp_re.pop_front();
          e_im = exp_im.pop_front();
          chk("dout_re_vs_model", int'(m_re), e_re);
          chk("dout_im_vs_model", int'(m_im), e_im);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  frame_t fr_re, fr_im;

  task automatic set_all(input int re, input int im);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = re;
      fr_im[k] = im;
    end
  endtask

  task automatic send_frame(input int n);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int g;
      logic [DBW-1:0] r4, i4;
      r4 = fr_re[k][DBW-1:0];
      i4 = fr_im[k][DBW-1:0];
      din = {i4, r4};
      din_valid = 1'b1;
      acc = 0;
      g = 0;
      while (!acc && g < 100) begin
        acc = (din_ready == 1'b1);
        @(posedge clk);
        #1;
        g++;
      end
      if (!acc) begin
        chk("din_accept_timeout", 0, 1);
        din_valid = 1'b0;
        return;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    g = 0;
    while ((exp_re.size() != 0 || dout_valid) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 200) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_log(input int target);
    int g;
    g = 0;
    while (log_re.size() < target && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) chk("wait_output_timeout", 0, 1);
  endtask

  task automatic chk_frame(input string tag, input int base, input frame_t er, input frame_t ei);
    chk($sformatf("%s_count", tag), log_re.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < log_re.size()) begin
        chk($sformatf("%s_re%0d", tag, i), log_re[base + i], er[i]);
        chk($sformatf("%s_im%0d", tag, i), log_im[base + i], ei[i]);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    frame_t er, ei, yr, yi;
    int base, t0, lat, frames, word, guard;
    bit acc;

    rst = 1'b1; clear = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;

    // Pin the reference model with hand-worked frames
    set_all(4, 0);
    ifft_model(fr_re, fr_im, yr, yi);
    chk("model_dc_re0", yr[0], 4);
    chk("model_dc_re3", yr[3], 0);
    set_all(0, 0); fr_re[1] = 4;
    ifft_model(fr_re, fr_im, yr, yi);
    chk("model_bin1_re3", yr[3], -1);
    chk("model_bin1_im5", yi[5], -1);
    chk("model_bin1_re5", yr[5], -1);
    chk("model_bin1_im7", yi[7], -1);
    set_all(0, 0); fr_re[0] = -1;
    ifft_model(fr_re, fr_im, yr, yi);
    chk("model_floor_re6", yr[6], -1);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("reset_din_ready", int'(din_ready), 1);
    chk("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_dout", int'(dout), 0);
    rst = 1'b0;

    // Impulse (7,-8): every sample (0,-1)
    set_all(0, 0); fr_re[0] = 7; fr_im[0] = -8;
    base = log_re.size();
    send_frame(8);
    drain();
    er = '{0, 0, 0, 0, 0, 0, 0, 0};
    ei = '{-1, -1, -1, -1, -1, -1, -1, -1};
    chk_frame("impulse78", base, er, ei);

    // Constant (4,0): x[0]=(4,0), rest zero, plus latency
    set_all(4, 0);
    base = log_re.size();
    send_frame(8);
    t0 = cyc;
    lat = -1;
    chk("latency_valid_low_at_accept", int'(dout_valid), 0);
    for (int g = 0; g < 60; g++) begin
      @(posedge clk);
      #1;
      if (dout_valid) begin
        lat = cyc - t0;
        break;
      end
    end
    chk("latency_edges", lat, 13);
    drain();
    er = '{4, 0, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_frame("dc4", base, er, ei);

    // Floor rounding: (-1,0) -> all -1; (1,0) -> all 0
    set_all(0, 0); fr_re[0] = -1;
    base = log_re.size();
    send_frame(8);
    drain();
    er = '{-1, -1, -1, -1, -1, -1, -1, -1};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_frame("neg1", base, er, ei);
    set_all(0, 0); fr_re[0] = 1;
    base = log_re.size();
    send_frame(8);
    drain();
    er = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_frame("pos1", base, er, ei);

    // Backpressure at n=3 on a bin-1 frame
    set_all(0, 0); fr_re[1] = 4;
    base = log_re.size();
    send_frame(8);
    dout_ready = 1'b1;
    wait_log(base + 3);
    dout_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_din_ready", int'(din_ready), 0);
      chk("bp_dout_valid", int'(dout_valid), 1);
    end
    drain();
    er = '{0, 0, 0, -1, -1, -1, 0, 0};
    ei = '{0, 0, 0, 0, 0, -1, -1, -1};
    chk_frame("bin1_bp", base, er, ei);

    // Clear after 5 bins, then an impulse (7,0)
    set_all(7, 7);
    send_frame(5);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk("clear_din_ready", int'(din_ready), 1);
    clear = 1'b0;
    set_all(0, 0); fr_re[0] = 7;
    base = log_re.size();
    send_frame(8);
    drain();
    er = '{0, 0, 0, 0, 0, 0, 0, 0};
    ei = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_frame("after_clear", base, er, ei);

    // Reset in the middle of UNLOAD
    set_all(4, 0);
    base = log_re.size();
    send_frame(8);
    dout_ready = 1'b1;
    wait_log(base + 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dout_valid", int'(dout_valid), 0);
    chk("midrst_din_ready", int'(din_ready), 1);
    chk("midrst_dout", int'(dout), 0);
    rst = 1'b0;
    set_all(0, 0); fr_re[0] = 7;
    base = log_re.size();
    send_frame(8);
    drain();
    chk_frame("after_rst", base, er, ei);

    // 1000 random frames, din_valid held high, random sink stalls
    frames = 0;
    word = 0;
    guard = 0;
    din = 8'($urandom);
    din_valid = 1'b1;
    while (frames < 1000 && guard < 60000) begin
      acc = (din_ready == 1'b1);
      dout_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        word++;
        if (word == 8) begin
          word = 0;
          frames++;
        end
        din = 8'($urandom);
      end
    end
    din_valid = 1'b0;
    chk("random_frames_done", frames, 1000);
    drain();
    chk("scoreboard_empty", exp_re.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
